// File: rtl/permutation_sequencer.sv
// Iterative sequencer for the Ascon-style round datapath. A request loads a
// 320-bit state and a round count; the sequencer then issues one round per
// clock by presenting the state and round index to an external combinational
// round function and registering its result. The final state is published in
// o_state alongside a one-cycle o_valid pulse.
module permutation_sequencer #(
  parameter int NB_ROUNDS_MAX = 12,
  parameter int ROUND_W       = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_start,
  input  logic [ROUND_W-1:0] i_rounds,
  input  logic [319:0]       i_state,
  output logic [ROUND_W-1:0] o_round,
  output logic [319:0]       o_round_state,
  input  logic [319:0]       i_round_state,
  output logic               o_ready,
  output logic               o_valid,
  output logic [319:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [ROUND_W-1:0] MAX_ROUNDS = ROUND_W'(NB_ROUNDS_MAX);
  localparam logic [ROUND_W-1:0] ONE        = ROUND_W'(1);

  fsm_t               fsm;
  logic [319:0]       state_reg;
  logic [ROUND_W-1:0] round_reg;
  logic [ROUND_W-1:0] count;
  logic [ROUND_W-1:0] neff;
  logic [ROUND_W-1:0] neff_in;

  // Saturate the requested round count to the number of constant slots.
  always_comb begin
    if (i_rounds > MAX_ROUNDS) begin
      neff_in = MAX_ROUNDS;
    end else begin
      neff_in = i_rounds;
    end
  end

  // The round function is fed straight from the working registers, so its
  // inputs only move while rounds are actually being issued.
  assign o_round       = round_reg;
  assign o_round_state = state_reg;

  // Sequencer FSM: load on accepted start, one round per clock, publish result.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm       <= IDLE;
      state_reg <= 320'd0;
      round_reg <= '0;
      count     <= '0;
      neff      <= '0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_state   <= 320'd0;
    end else begin
      o_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (i_start) begin
            state_reg <= i_state;
            // Rounds always end on the last constant slot, so a short
            // request starts part-way into the constant table.
            round_reg <= MAX_ROUNDS - neff_in;
            neff      <= neff_in;
            count     <= '0;
            o_ready   <= 1'b0;
            if (neff_in == '0) begin
              fsm <= DONE;
            end else begin
              fsm <= RUN;
            end
          end
        end
        RUN: begin
          state_reg <= i_round_state;
          if (count == neff - ONE) begin
            // Keep the index on the last slot instead of stepping past it.
            fsm <= DONE;
          end else begin
            round_reg <= round_reg + ONE;
            count     <= count + ONE;
          end
        end
        DONE: begin
          o_state <= state_reg;
          o_valid <= 1'b1;
          o_ready <= 1'b1;
          fsm     <= IDLE;
        end
        default: begin
          fsm     <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
